// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection among ALU/LSU/MDU results,
// a registered single-port regfile write, and the pending-write scoreboard.
module wb_arbiter #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [XLEN-1:0]           lsu_data,
    input  logic                      mdu_valid,
    output logic                      mdu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_rd,
    input  logic [XLEN-1:0]           mdu_data,
    input  logic                      sb_set_en,
    input  logic [REG_ADDR_WIDTH-1:0] sb_set_addr,
    input  logic                      flush,
    output logic                      rd_wen,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic [NUM_REGS-1:0]       busy
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_t;

    src_t                      rr_ptr;
    src_t                      rr_ptr_next;
    src_t                      grant_idx;
    logic                      grant_vld;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [XLEN-1:0]           sel_data;
    logic                      sel_writes;
    logic [NUM_REGS-1:0]       busy_next;

    // Round-robin search starting at rr_ptr; blocked entirely during reset or flush
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = SRC_ALU;
        case (rr_ptr)
            SRC_LSU: begin
                if (lsu_valid)      begin grant_vld = 1'b1; grant_idx = SRC_LSU; end
                else if (mdu_valid) begin grant_vld = 1'b1; grant_idx = SRC_MDU; end
                else if (alu_valid) begin grant_vld = 1'b1; grant_idx = SRC_ALU; end
            end
            SRC_MDU: begin
                if (mdu_valid)      begin grant_vld = 1'b1; grant_idx = SRC_MDU; end
                else if (alu_valid) begin grant_vld = 1'b1; grant_idx = SRC_ALU; end
                else if (lsu_valid) begin grant_vld = 1'b1; grant_idx = SRC_LSU; end
            end
            default: begin
                if (alu_valid)      begin grant_vld = 1'b1; grant_idx = SRC_ALU; end
                else if (lsu_valid) begin grant_vld = 1'b1; grant_idx = SRC_LSU; end
                else if (mdu_valid) begin grant_vld = 1'b1; grant_idx = SRC_MDU; end
            end
        endcase
        if (rst || flush) begin
            grant_vld = 1'b0;
        end
    end

    // A granted source is always valid, so ready==grant means a transfer this edge
    assign alu_ready = grant_vld && (grant_idx == SRC_ALU);
    assign lsu_ready = grant_vld && (grant_idx == SRC_LSU);
    assign mdu_ready = grant_vld && (grant_idx == SRC_MDU);

    // Select destination and data of the granted source
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        case (grant_idx)
            SRC_LSU: begin sel_rd = lsu_rd; sel_data = lsu_data; end
            SRC_MDU: begin sel_rd = mdu_rd; sel_data = mdu_data; end
            default: begin sel_rd = alu_rd; sel_data = alu_data; end
        endcase
        sel_writes = grant_vld && (sel_rd != '0);
    end

    // Pointer moves one past the winner on a transfer, otherwise holds
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_vld) begin
            case (grant_idx)
                SRC_ALU: rr_ptr_next = SRC_LSU;
                SRC_LSU: rr_ptr_next = SRC_MDU;
                default: rr_ptr_next = SRC_ALU;
            endcase
        end
    end

    // Scoreboard: commit clears first, then issue sets so a new writer wins
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (sel_writes) begin
                busy_next[sel_rd] = 1'b0;
            end
            if (sb_set_en && (sb_set_addr != '0)) begin
                busy_next[sb_set_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Arbiter pointer, output register and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= SRC_ALU;
            rd_wen  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
            busy    <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            rd_wen <= sel_writes;
            if (grant_vld) begin
                rd_addr <= sel_rd;
                rd_data <= sel_data;
            end
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table followed by randomized traffic
// compared against a cycle-level reference model of the writeback rules.
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int XL = 64;
    localparam int NR = 32;
    localparam logic [XL-1:0] DA = 64'hDEAD_BEEF_CAFE_BABE;
    localparam logic [XL-1:0] DL = 64'h1111_1111_1111_1111;
    localparam logic [XL-1:0] DM = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          sb_set_en;
    logic [AW-1:0] sb_set_addr;
    logic [2:0]    src_valid;
    logic [2:0]    src_ready;
    logic [AW-1:0] src_rd   [3];
    logic [XL-1:0] src_data [3];
    logic          rd_wen;
    logic [AW-1:0] rd_addr;
    logic [XL-1:0] rd_data;
    logic [NR-1:0] busy;

    wb_arbiter #(.XLEN(XL), .REG_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (src_valid[0]),
        .alu_ready  (src_ready[0]),
        .alu_rd     (src_rd[0]),
        .alu_data   (src_data[0]),
        .lsu_valid  (src_valid[1]),
        .lsu_ready  (src_ready[1]),
        .lsu_rd     (src_rd[1]),
        .lsu_data   (src_data[1]),
        .mdu_valid  (src_valid[2]),
        .mdu_ready  (src_ready[2]),
        .mdu_rd     (src_rd[2]),
        .mdu_data   (src_data[2]),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr),
        .flush      (flush),
        .rd_wen     (rd_wen),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          flush;
        logic [2:0]    v;
        logic [AW-1:0] ard;
        logic [AW-1:0] lrd;
        logic [AW-1:0] mrd;
        logic          sb_en;
        logic [AW-1:0] sb_addr;
        logic [2:0]    e_rdy;
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic [XL-1:0] e_data;
        logic [NR-1:0] e_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_ptr;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [XL-1:0] m_data;
    logic [NR-1:0] m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [2:0] v,
                                input int ard, input int lrd, input int mrd,
                                input logic se, input int sa, input logic [2:0] er,
                                input logic ew, input int ea, input logic [XL-1:0] ed,
                                input logic [NR-1:0] eb);
        vec_t t;
        t.rst = r; t.flush = f; t.v = v;
        t.ard = AW'(ard); t.lrd = AW'(lrd); t.mrd = AW'(mrd);
        t.sb_en = se; t.sb_addr = AW'(sa);
        t.e_rdy = er; t.e_wen = ew; t.e_addr = AW'(ea); t.e_data = ed; t.e_busy = eb;
        return t;
    endfunction

    // Winner: first valid source scanning upward from the pointer, modulo 3
    function automatic int model_grant();
        if (rst || flush) return -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_ptr + k) % 3;
            if (src_valid[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        if (rst) begin
            m_wen = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_ptr = 0;
        end else begin
            m_wen = 1'b0;
            if (g >= 0) begin
                m_wen  = (src_rd[g] != 0);
                m_addr = src_rd[g];
                m_data = src_data[g];
                m_ptr  = (g + 1) % 3;
            end
            if (flush) begin
                m_busy = '0;
            end else begin
                if (g >= 0 && src_rd[g] != 0) m_busy[src_rd[g]] = 1'b0;
                if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
            end
        end
    endtask

    // One clock: check readys before the edge, outputs just after it
    task automatic step(input bit use_exp, input string tag, input vec_t v, output int g);
        logic [2:0] mr;
        #1;
        g  = model_grant();
        mr = (g < 0) ? 3'b000 : 3'(1 << g);
        chk({tag, " ready(model)"}, 64'(src_ready), 64'(mr));
        if (use_exp) chk({tag, " ready"}, 64'(src_ready), 64'(v.e_rdy));
        @(posedge clk);
        model_edge(g);
        #1;
        chk({tag, " rd_wen(model)"}, 64'(rd_wen), 64'(m_wen));
        chk({tag, " rd_addr(model)"}, 64'(rd_addr), 64'(m_addr));
        chk({tag, " rd_data(model)"}, rd_data, m_data);
        chk({tag, " busy(model)"}, 64'(busy), 64'(m_busy));
        if (use_exp) begin
            chk({tag, " rd_wen"}, 64'(rd_wen), 64'(v.e_wen));
            chk({tag, " rd_addr"}, 64'(rd_addr), 64'(v.e_addr));
            chk({tag, " rd_data"}, rd_data, v.e_data);
            chk({tag, " busy"}, 64'(busy), 64'(v.e_busy));
        end
    endtask

    vec_t vecs [25];

    initial begin
        int g;
        vec_t dummy;

        //                rst flush v     ard lrd mrd se sa  e_rdy  ew ea ed  e_busy
        vecs[0]  = mk(1, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 0, '0, '0);
        vecs[1]  = mk(1, 0, 3'b111, 2, 3, 4, 0, 0,  3'b000, 0, 0, '0, '0);
        vecs[2]  = mk(0, 0, 3'b001, 1, 0, 0, 0, 0,  3'b001, 1, 1, DA, '0);
        vecs[3]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 1, DA, '0);
        vecs[4]  = mk(0, 0, 3'b000, 0, 0, 0, 1, 5,  3'b000, 0, 1, DA, 32'h20);
        vecs[5]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 1, DA, 32'h20);
        vecs[6]  = mk(0, 0, 3'b010, 0, 5, 0, 0, 0,  3'b010, 1, 5, DL, '0);
        vecs[7]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 5, DL, '0);
        vecs[8]  = mk(0, 0, 3'b100, 0, 0, 0, 1, 0,  3'b100, 0, 0, DM, '0);
        vecs[9]  = mk(0, 0, 3'b000, 0, 0, 0, 1, 7,  3'b000, 0, 0, DM, 32'h80);
        vecs[10] = mk(0, 0, 3'b000, 0, 0, 0, 1, 9,  3'b000, 0, 0, DM, 32'h280);
        vecs[11] = mk(0, 0, 3'b001, 9, 0, 0, 1, 9,  3'b001, 1, 9, DA, 32'h280);
        vecs[12] = mk(0, 1, 3'b010, 0, 3, 0, 1, 4,  3'b000, 0, 9, DA, '0);
        vecs[13] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 9, DA, '0);
        vecs[14] = mk(0, 0, 3'b000, 0, 0, 0, 1, 12, 3'b000, 0, 9, DA, 32'h1000);
        vecs[15] = mk(0, 0, 3'b010, 0, 12, 0, 1, 20, 3'b010, 1, 12, DL, 32'h100000);
        vecs[16] = mk(1, 0, 3'b111, 2, 3, 4, 1, 6,  3'b000, 0, 0, '0, '0);
        vecs[17] = mk(0, 0, 3'b111, 2, 3, 4, 0, 0,  3'b001, 1, 2, DA, '0);
        vecs[18] = mk(0, 0, 3'b111, 2, 3, 4, 0, 0,  3'b010, 1, 3, DL, '0);
        vecs[19] = mk(0, 0, 3'b111, 2, 3, 4, 0, 0,  3'b100, 1, 4, DM, '0);
        vecs[20] = mk(0, 0, 3'b111, 2, 3, 4, 0, 0,  3'b001, 1, 2, DA, '0);
        vecs[21] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 2, DA, '0);
        vecs[22] = mk(0, 0, 3'b001, 6, 0, 0, 0, 0,  3'b001, 1, 6, DA, '0);
        vecs[23] = mk(0, 0, 3'b101, 6, 0, 7, 0, 0,  3'b100, 1, 7, DM, '0);
        vecs[24] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0,  3'b000, 0, 7, DM, '0);

        m_ptr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
        src_data[0] = DA; src_data[1] = DL; src_data[2] = DM;

        for (int i = 0; i < 25; i++) begin
            rst         = vecs[i].rst;
            flush       = vecs[i].flush;
            src_valid   = vecs[i].v;
            src_rd[0]   = vecs[i].ard;
            src_rd[1]   = vecs[i].lrd;
            src_rd[2]   = vecs[i].mrd;
            sb_set_en   = vecs[i].sb_en;
            sb_set_addr = vecs[i].sb_addr;
            step(1'b1, $sformatf("vec%0d", i), vecs[i], g);
        end

        // Randomized traffic; sources hold valid/rd/data until accepted
        dummy = vecs[0];
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            sb_set_en   = ($urandom_range(0, 1) == 1);
            sb_set_addr = AW'($urandom_range(0, 31));
            step(1'b0, $sformatf("rnd%0d", n), dummy, g);
            for (int s = 0; s < 3; s++) begin
                if (g == s || !src_valid[s]) begin
                    src_valid[s] = ($urandom_range(0, 9) < 6);
                    src_rd[s]    = AW'($urandom_range(0, 31));
                    src_data[s]  = {$urandom, $urandom};
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
